cla_subtractor_serial: RTL and testbench

Nibble-serial multi-cycle subtractor, the inverse-direction companion to the team's 4-bit carry-lookahead adder. Computes D = A − B − Bin on WIDTH-bit operands, processing one 4-bit slice per clock through an internal 4-bit generate/propagate lookahead slice, with a borrow register chaining slices. Used where a full-width subtract is not timing-critical and a small datapath is preferred. A start/busy/done handshake lets a controller launch one operation and collect results plus flags.

---
 rtl/cla_subtractor_serial_if.sv | 26 ++
 rtl/cla_subtractor_serial.sv | 129 ++++++++++++
 tb/tb_cla_subtractor_serial.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cla_subtractor_serial_if.sv
// Start/busy/done handshake bundle for the nibble-serial subtractor.
// The controller drives the master side; the subtractor is the slave.
interface cla_subtractor_serial_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout, ovf, zero
  );
endinterface

// File: rtl/cla_subtractor_serial.sv
// Nibble-serial subtractor D = A - B - Bin: one 4-bit lookahead slice per cycle,
// with a carry register chaining the slices (carry = ~borrow).
module cla_subtractor_serial #(
  parameter int unsigned WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  cla_subtractor_serial_if.slave bus
);

  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic [WIDTH-1:0]   res_q, res_n;
  logic               c_q, c_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic [WIDTH-1:0]   d_q, d_n;
  logic               bout_q, bout_n;
  logic               ovf_q, ovf_n;
  logic               zero_q, zero_n;

  logic [3:0] x, y, p, g, s;
  logic       c1, c2, c3, c4;

  // One 4-bit generate/propagate lookahead slice on the current nibble
  always_comb begin
    x  = a_q[idx_q*4 +: 4];
    y  = ~b_q[idx_q*4 +: 4];
    p  = x ^ y;
    g  = x & y;
    c1 = g[0] | (p[0] & c_q);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c_q);
    s  = p ^ {c3, c2, c1, c_q};
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    a_n        = a_q;
    b_n        = b_q;
    res_n      = res_q;
    c_n        = c_q;
    idx_n      = idx_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    d_n        = d_q;
    bout_n     = bout_q;
    ovf_n      = ovf_q;
    zero_n     = zero_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          a_n        = bus.a;
          b_n        = bus.b;
          c_n        = ~bus.bin;
          idx_n      = '0;
          busy_n     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        res_n[idx_q*4 +: 4] = s;
        c_n                 = c4;
        if (idx_q == IDX_W'(N - 1)) begin
          d_n        = res_n;
          bout_n     = ~c4;
          ovf_n      = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res_n[WIDTH-1] ^ a_q[WIDTH-1]);
          zero_n     = (res_n == '0);
          done_n     = 1'b1;
          busy_n     = 1'b0;
          idx_n      = '0;
          state_next = IDLE;
        end else begin
          idx_n = idx_q + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      c_q    <= 1'b0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_next;
      a_q    <= a_n;
      b_q    <= b_n;
      res_q  <= res_n;
      c_q    <= c_n;
      idx_q  <= idx_n;
      busy_q <= busy_n;
      done_q <= done_n;
      d_q    <= d_n;
      bout_q <= bout_n;
      ovf_q  <= ovf_n;
      zero_q <= zero_n;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_cla_subtractor_serial.sv
// Directed bench for cla_subtractor_serial (WIDTH=16): results, flags, latency,
// ignored/back-to-back start and mid-operation reset.
module tb_cla_subtractor_serial;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cla_subtractor_serial_if #(.WIDTH(16)) bus ();

  cla_subtractor_serial #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following posedge (edge E)
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = bi;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Starts at the negedge after E; returns cycles until done and busy-high count
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_op(input string tag, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
    int cyc;
    int bc;
    wait_done(cyc, bc);
    chk({tag, "_lat"},  32'(cyc), 32'd4);
    chk({tag, "_busy"}, 32'(bc), 32'd4);
    chk({tag, "_bsy0"}, 32'(bus.busy), 32'd0);
    chk({tag, "_d"},    32'(bus.d), 32'(ed));
    chk({tag, "_flg"},  32'({bus.bout, bus.ovf, bus.zero}), 32'({eb, eo, ez}));
  endtask

  initial begin
    int cyc;
    int bc;
    int stray;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vals", 32'({bus.busy, bus.done, bus.bout, bus.ovf, bus.zero}), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(16'h1234, 16'h0234, 1'b0);
    check_op("basic", 16'h1000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("d_hold", 32'(bus.d), 32'h1000);

    launch(16'h0000, 16'h0001, 1'b0); check_op("underflow", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    launch(16'h0100, 16'h0001, 1'b0); check_op("xnibble",   16'h00FF, 1'b0, 1'b0, 1'b0);
    launch(16'h8000, 16'h0001, 1'b0); check_op("ovf_neg",   16'h7FFF, 1'b0, 1'b1, 1'b0);
    launch(16'h7FFF, 16'hFFFF, 1'b0); check_op("ovf_pos",   16'h8000, 1'b1, 1'b1, 1'b0);
    launch(16'h5555, 16'h5554, 1'b1); check_op("zero_bin",  16'h0000, 1'b0, 1'b0, 1'b1);
    launch(16'h0005, 16'h0005, 1'b1); check_op("bin_wrap",  16'hFFFF, 1'b1, 1'b0, 1'b0);
    launch(16'hFFFF, 16'hFFFF, 1'b0); check_op("eq_zero",   16'h0000, 1'b0, 1'b0, 1'b1);

    // start pulsed mid-run with new operands must be ignored; d holds meanwhile
    launch(16'h1234, 16'h0034, 1'b0);
    @(negedge clk);
    chk("run_hold", 32'(bus.d), 32'h0000);
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0000;
    bus.bin   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bc);
    chk("ign_lat", 32'(cyc), 32'd2);
    chk("ign_d", 32'(bus.d), 32'h1200);

    // start held in the done cycle starts a second op immediately
    launch(16'hABCD, 16'h0BCD, 1'b0);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    check_op("b2b", 16'hA000, 1'b0, 1'b0, 1'b0);

    // reset during slice 2 abandons the op without a done pulse
    @(negedge clk);
    launch(16'h4321, 16'h0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_vals", 32'({bus.busy, bus.done, bus.bout, bus.ovf, bus.zero}), 32'd0);
    chk("mrst_d", 32'(bus.d), 32'd0);
    rst   = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    chk("mrst_nodone", 32'(stray), 32'd0);
    launch(16'h0100, 16'h0101, 1'b0);
    check_op("post_rst", 16'hFFFF, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
